// File: rtl/servo_pwm_decoder.sv
// ----------------------------------------------------------------------------
// servo_pwm_decoder
//
// Measures the high time of an incoming 50 Hz servo-style PWM signal and
// decodes it back into the flag command (0 = bajar / 1 ms, 1 = subir / 1.5 ms).
// Out-of-range pulses are rejected with an error strobe, and a missing input
// (no rising edge within TIMEOUT_CLKS) is reported as loss of signal, with the
// decoded command forced to the fail-safe "flag down" value.
//
// Ports:
//   clk              in   system clock (single domain)
//   reset_n          in   asynchronous reset, active-low
//   pwm_in           in   asynchronous PWM input
//   pulse_width      out  high time, in clocks, of the last accepted pulse
//   comando_banderin out  decoded command (width >= THRESHOLD_CLKS -> 1)
//   pulse_valid      out  1-cycle strobe: an accepted pulse was just measured
//   pulse_error      out  1-cycle strobe: a pulse outside [MIN, MAX] was rejected
//   signal_lost      out  level: no rising edge seen within TIMEOUT_CLKS
//
// All outputs are registered; pwm_in only reaches them through the
// synchronizer and the FSM/counter registers.
// ----------------------------------------------------------------------------
module servo_pwm_decoder #(
    parameter int CLK_FREQ_HZ    = 25_000_000,
    parameter int PULSE_MIN_CLKS = 12_500,
    parameter int PULSE_MAX_CLKS = 62_500,
    parameter int THRESHOLD_CLKS = 31_250,
    parameter int TIMEOUT_CLKS   = 750_000,
    parameter int COUNTER_BITS   = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pwm_in,
    output logic [COUNTER_BITS-1:0] pulse_width,
    output logic                    comando_banderin,
    output logic                    pulse_valid,
    output logic                    pulse_error,
    output logic                    signal_lost
);

    localparam logic [COUNTER_BITS-1:0] MIN_C      = COUNTER_BITS'(PULSE_MIN_CLKS);
    localparam logic [COUNTER_BITS-1:0] MAX_C      = COUNTER_BITS'(PULSE_MAX_CLKS);
    localparam logic [COUNTER_BITS-1:0] THRESH_C   = COUNTER_BITS'(THRESHOLD_CLKS);
    localparam logic [COUNTER_BITS-1:0] TIMEOUT_C  = COUNTER_BITS'(TIMEOUT_CLKS);
    // The high counter stops one above MAX so an over-long pulse is still
    // recognised as too long without the counter wrapping.
    localparam logic [COUNTER_BITS-1:0] HIGH_SAT_C = COUNTER_BITS'(PULSE_MAX_CLKS + 1);
    localparam logic [COUNTER_BITS-1:0] ONE_C      = COUNTER_BITS'(1);

    // The clock frequency is informational only; this block exists solely so
    // the parameter is referenced. It elaborates to nothing.
    if (CLK_FREQ_HZ <= 0) begin : g_clk_freq_unset
    end

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE
    } state_t;

    state_t                  state_q, state_d;
    logic                    s1_q, s1_d;      // first synchronizer stage
    logic                    s_q, s_d;        // synchronized input
    logic                    p_q, p_d;        // previous synchronized input
    logic [2:0]              prime_q, prime_d;
    logic [COUNTER_BITS-1:0] high_cnt_q, high_cnt_d;
    logic [COUNTER_BITS-1:0] period_cnt_q, period_cnt_d;
    logic [COUNTER_BITS-1:0] pulse_width_q, pulse_width_d;
    logic                    cmd_q, cmd_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic                    lost_q, lost_d;

    logic                    rise;
    logic                    fall;
    logic                    in_range;
    logic                    timeout_hit;

    // The synchronizer flops come out of reset as 0, which is not a real
    // sample of pwm_in. prime_q tracks how many stages hold genuine samples:
    // bit 1 -> s is real, bit 2 -> p is real too. Edges are only believed once
    // both s and p are real, so an input already high at reset release is not
    // mistaken for a rising edge and a partial pulse is never measured.
    assign rise     = prime_q[2] &  s_q & ~p_q;
    assign fall     = prime_q[2] & ~s_q &  p_q;
    assign in_range = (high_cnt_q >= MIN_C) && (high_cnt_q <= MAX_C);

    always_comb begin
        state_d       = state_q;
        s1_d          = pwm_in;
        s_d           = s1_q;
        p_d           = s_q;
        prime_d       = {prime_q[1:0], 1'b1};
        high_cnt_d    = high_cnt_q;
        period_cnt_d  = period_cnt_q;
        pulse_width_d = pulse_width_q;
        cmd_d         = cmd_q;
        valid_d       = 1'b0;
        error_d       = 1'b0;
        lost_d        = lost_q;
        timeout_hit   = 1'b0;

        // Period counter runs in every state, so a stuck-high input still
        // times out.
        if (rise) begin
            period_cnt_d = '0;
        end else if (period_cnt_q != TIMEOUT_C) begin
            period_cnt_d = period_cnt_q + ONE_C;
            timeout_hit  = (period_cnt_q + ONE_C == TIMEOUT_C);
        end

        unique case (state_q)
            WAIT_LOW: begin
                // Only leave once s is a genuine sample and shows the input low.
                if (prime_q[1] && !s_q) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d    = MEASURE;
                    high_cnt_d = ONE_C;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                    if (in_range) begin
                        pulse_width_d = high_cnt_q;
                        cmd_d         = (high_cnt_q >= THRESH_C);
                        valid_d       = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (s_q && high_cnt_q != HIGH_SAT_C) begin
                    high_cnt_d = high_cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase

        // Loss of signal is evaluated after the pulse so the fail-safe command
        // wins over a pulse evaluated in the same cycle. It only forces the
        // command on the cycle the timeout is reached, so pulses accepted
        // while the signal is still flagged as lost update it normally.
        if (rise) begin
            lost_d = 1'b0;
        end else if (timeout_hit) begin
            lost_d = 1'b1;
            cmd_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOW;
            s1_q          <= 1'b0;
            s_q           <= 1'b0;
            p_q           <= 1'b0;
            prime_q       <= '0;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            pulse_width_q <= '0;
            cmd_q         <= 1'b0;
            valid_q       <= 1'b0;
            error_q       <= 1'b0;
            lost_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s_q           <= s_d;
            p_q           <= p_d;
            prime_q       <= prime_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            pulse_width_q <= pulse_width_d;
            cmd_q         <= cmd_d;
            valid_q       <= valid_d;
            error_q       <= error_d;
            lost_q        <= lost_d;
        end
    end

    assign pulse_width      = pulse_width_q;
    assign comando_banderin = cmd_q;
    assign pulse_valid      = valid_q;
    assign pulse_error      = error_q;
    assign signal_lost      = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// ----------------------------------------------------------------------------
// tb_servo_pwm_decoder
//
// Directed bench for servo_pwm_decoder with scaled-down timing parameters.
// Every pulse pushes its expected strobe (kind, width, command, cycle) into a
// scoreboard queue when the input falls; a monitor pops and compares whenever
// the DUT strobes. Timeout and reset behaviour are checked inline.
// ----------------------------------------------------------------------------
module tb_servo_pwm_decoder;

    localparam int MIN = 20;
    localparam int MAX = 100;
    localparam int THR = 50;
    localparam int TMO = 1000;
    localparam int CB  = 12;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in  = 1'b0;
    logic [CB-1:0] pulse_width;
    logic          comando_banderin;
    logic          pulse_valid;
    logic          pulse_error;
    logic          signal_lost;

    servo_pwm_decoder #(
        .CLK_FREQ_HZ   (25_000_000),
        .PULSE_MIN_CLKS(MIN),
        .PULSE_MAX_CLKS(MAX),
        .THRESHOLD_CLKS(THR),
        .TIMEOUT_CLKS  (TMO),
        .COUNTER_BITS  (CB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pwm_in          (pwm_in),
        .pulse_width     (pulse_width),
        .comando_banderin(comando_banderin),
        .pulse_valid     (pulse_valid),
        .pulse_error     (pulse_error),
        .signal_lost     (signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int width;
        bit cmd;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   model_width = 0;
    bit   model_cmd = 1'b0;
    int   high_start = 0;
    int   last_rise = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: one line per transaction.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pulse_valid || pulse_error) begin
                check("strobe_exclusive", 32'(pulse_valid & pulse_error), 0);
                checks++;
                assert (sbq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_strobe observed valid=%0b error=%0b at cycle %0d expected no strobe",
                           pulse_valid, pulse_error, cyc);
                end
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    $display("cycle %0d: strobe %s width=%0d cmd=%0b (expect %s width=%0d cmd=%0b)",
                             cyc, pulse_error ? "error" : "valid", pulse_width, comando_banderin,
                             e.is_err ? "error" : "valid", e.width, e.cmd);
                    check("strobe_kind_error", 32'(pulse_error), 32'(e.is_err));
                    check("strobe_width", 32'(pulse_width), e.width);
                    check("strobe_cmd", 32'(comando_banderin), 32'(e.cmd));
                    check("strobe_cycle", cyc, e.at);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].at) begin
                check("strobe_missing_cycle", cyc, sbq[0].at);
                void'(sbq.pop_front());
            end
        end
    end

    // Raise the input at a falling edge; optionally check that signal_lost
    // drops exactly on the third sampling edge.
    task automatic go_high(input bit chk_rise);
        pwm_in     = 1'b1;
        high_start = cyc;
        last_rise  = cyc + 3;
        if (chk_rise) begin
            repeat (2) @(negedge clk);
            check("lost_before_rise_edge3", 32'(signal_lost), 1);
            @(negedge clk);
            check("lost_cleared_by_rise", 32'(signal_lost), 0);
        end
    endtask

    // Drop the input and push the expected strobe for the finished pulse.
    task automatic go_low(input int lo);
        exp_t e;
        int   w;
        w = cyc - high_start;
        if (w >= MIN && w <= MAX) begin
            model_width = w;
            model_cmd   = (w >= THR);
            e.is_err    = 1'b0;
        end else begin
            e.is_err    = 1'b1;
        end
        e.width = model_width;
        e.cmd   = model_cmd;
        e.at    = cyc + 3;
        sbq.push_back(e);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo, input bit chk_rise);
        go_high(chk_rise);
        while (cyc < high_start + hi) @(negedge clk);
        go_low(lo);
    endtask

    // signal_lost must rise exactly TMO edges after the edge that registered
    // the last rise, forcing the command low and holding the width.
    task automatic check_timeout(input string tag);
        int t;
        t = last_rise + TMO;
        while (cyc < t - 1) @(negedge clk);
        check({tag, "_lost_early"}, 32'(signal_lost), 0);
        check({tag, "_cmd_early"}, 32'(comando_banderin), 32'(model_cmd));
        @(negedge clk);
        $display("cycle %0d: %s lost=%0b cmd=%0b width=%0d", cyc, tag, signal_lost,
                 comando_banderin, pulse_width);
        check({tag, "_lost"}, 32'(signal_lost), 1);
        check({tag, "_cmd_forced"}, 32'(comando_banderin), 0);
        check({tag, "_width_hold"}, 32'(pulse_width), model_width);
        model_cmd = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_width"}, 32'(pulse_width), 0);
        check({tag, "_cmd"}, 32'(comando_banderin), 0);
        check({tag, "_valid"}, 32'(pulse_valid), 0);
        check({tag, "_error"}, 32'(pulse_error), 0);
        check({tag, "_lost"}, 32'(signal_lost), 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal 1 ms-equivalent pulses
        pulse(40, 260, 1'b1);
        pulse(40, 260, 1'b0);
        pulse(40, 260, 1'b0);

        // Threshold decisions
        pulse(75, 225, 1'b0);
        pulse(49, 251, 1'b0);
        pulse(50, 250, 1'b0);

        // Range limits, saturation, minimum strobe spacing
        pulse(19, 100, 1'b0);
        pulse(101, 100, 1'b0);
        pulse(120, 100, 1'b0);
        pulse(20, 100, 1'b0);
        pulse(100, 100, 1'b0);
        pulse(1, 1, 1'b0);
        pulse(1, 30, 1'b0);

        // Loss of signal with the input held low
        pulse(75, 100, 1'b0);
        check_timeout("tmo_low");

        // Loss of signal with the input stuck high
        pulse(60, 100, 1'b1);
        go_high(1'b0);
        check_timeout("tmo_high");
        repeat (50) @(negedge clk);
        go_low(100);
        pulse(40, 260, 1'b1);

        // Reset in the middle of a pulse, released while still high
        repeat (10) @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midpulse_reset");
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        model_width = 0;
        model_cmd   = 1'b0;
        repeat (20) @(negedge clk);
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        pulse(75, 200, 1'b1);

        // Loopback-style command toggling every 3 periods
        for (int p = 0; p < 12; p++) begin
            pulse((((p / 3) % 2) != 0) ? 60 : 40, 240, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("queue_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/servo_pwm_decoder.md
# servo_pwm_decoder

Receive-side counterpart of the servo PWM generator: measures the high time of an incoming 50 Hz servo-style PWM signal and decodes it back into the flag command (0 = bajar/1 ms, 1 = subir/1.5 ms). It is used for loopback self-test of the flag servo path and for accepting flag commands from an external PWM source. It also flags out-of-range pulses and loss of signal. Single 25 MHz clock domain; `pwm_in` is asynchronous.

## Interface

Parameters:
- `CLK_FREQ_HZ`, 25_000_000: clock frequency. Informational only; all other values are given in clocks.
- `PULSE_MIN_CLKS`, 12_500: shortest accepted pulse (0.5 ms), inclusive.
- `PULSE_MAX_CLKS`, 62_500: longest accepted pulse (2.5 ms), inclusive.
- `THRESHOLD_CLKS`, 31_250: decision point (1.25 ms). Width >= threshold decodes as 1.
- `TIMEOUT_CLKS`, 750_000: maximum rise-to-rise gap (30 ms) before loss of signal is declared.
- `COUNTER_BITS`, 20: width of the internal counters and of `pulse_width`. Must satisfy 2^COUNTER_BITS > TIMEOUT_CLKS.

Ports:
- `clk` in 1: 25 MHz system clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `pwm_in` in 1: asynchronous PWM input.
- `pulse_width` out COUNTER_BITS: high time, in clocks, of the last accepted pulse.
- `comando_banderin` out 1: decoded command.
- `pulse_valid` out 1: 1-cycle strobe; an accepted pulse has just been measured.
- `pulse_error` out 1: 1-cycle strobe; a pulse outside [MIN, MAX] has been rejected.
- `signal_lost` out 1: level; no rising edge seen within TIMEOUT_CLKS.

## Operation

Input conditioning:
- `pwm_in` passes through a 2-FF synchronizer (`s`) and one further register (`p`).
- rise = `s & ~p`; fall = `~s & p`.

FSM states:
- WAIT_LOW is the reset state. It ignores any pulse already in progress and moves to WAIT_RISE when `s` = 0.
- WAIT_RISE moves to MEASURE on rise.
- MEASURE moves to WAIT_RISE on fall, at which point the pulse is evaluated.

High counter:
- Loaded with 1 on rise.
- Increments on each cycle in MEASURE with `s` = 1.
- Saturates at PULSE_MAX_CLKS+1.
- At fall it equals the number of cycles `s` was high.

Pulse evaluation, on fall:
- If MIN <= count <= MAX: `pulse_width` <= count, `comando_banderin` <= (count >= THRESHOLD_CLKS), and `pulse_valid` pulses.
- Otherwise `pulse_error` pulses, and `pulse_width` and `comando_banderin` hold their values.

Period counter:
- Cleared on every rise.
- Otherwise increments, saturating at TIMEOUT_CLKS.
- Counts in all states, including a stuck-high input.

Loss of signal:
- `signal_lost` sets on the cycle the period counter reaches TIMEOUT_CLKS.
- At the same time `comando_banderin` is forced to 0 (fail-safe: flag down); `pulse_width` holds.
- `signal_lost` clears on the next rise.
- While `signal_lost` is set, a subsequent accepted pulse updates `comando_banderin` normally.

Simultaneous events:
- A timeout in the same cycle as a fall: evaluation happens first, then the forced 0 wins for `comando_banderin`.
- `pulse_valid` and `pulse_error` are never asserted together.

Reset values:
- `pulse_width` = 0, `comando_banderin` = 0, `pulse_valid` = 0, `pulse_error` = 0, `signal_lost` = 1.
- FSM = WAIT_LOW, all counters and synchronizer flops = 0.

Reset mid-pulse: all state clears immediately. After release the FSM stays in WAIT_LOW, so the partial pulse produces neither `pulse_valid` nor `pulse_error`.

## Timing

- Latency from the first clock edge sampling `pwm_in` low to `pulse_valid`/`pulse_error` high: 3 clock edges (2 synchronizer + 1 output register).
- `pulse_width` and `comando_banderin` update on that same edge.
- Latency from the first edge sampling `pwm_in` high to `signal_lost` deasserting: 3 edges.
- A clock-aligned input pulse high for exactly N cycles yields `pulse_width` = N. An asynchronous pulse yields N ±1.
- `signal_lost` asserts exactly TIMEOUT_CLKS cycles after the cycle in which the last rise was detected.
- Strobes are exactly 1 cycle wide. The minimum spacing between strobes is 2 cycles (a 1-cycle high followed by a 1-cycle low).
- Every output is registered; there is no combinational path from `pwm_in` to any output.

## Test plan

1. Reset, then drive 25_000-clk pulses at a 500_000-clk period → `pulse_valid` once per period, `pulse_width` = 25_000, `comando_banderin` = 0, `signal_lost` falls 3 cycles after the first rise.
2. Pulses of 37_500 / 31_249 / 31_250 clks → `comando_banderin` = 1 / 0 / 1, each with `pulse_valid`.
3. Pulses of 12_499 and 62_501 → `pulse_error`, outputs hold the previous values. Pulses of 12_500 and 62_500 → `pulse_valid`, `pulse_width` = 12_500 and 62_500 respectively.
4. After a 37_500 pulse, hold input low → `signal_lost` = 1 and `comando_banderin` = 0 exactly 750_000 cycles after the rise detection. Repeat with input held high → same result. Resume pulses → `signal_lost` clears 3 cycles after the rise.
5. Assert `reset_n` low mid-pulse and release while `pwm_in` is still high → no strobe for that pulse; the next full 37_500 pulse gives `pulse_valid`, `comando_banderin` = 1.
6. Loop back from the servo PWM generator and toggle its command every 3 periods → `comando_banderin` follows within one period, with no `pulse_error`.
